z_velocity_scheduler: RTL and testbench
=======================================

Name: z_velocity_scheduler

Overview:
Sequencing controller in front of the z-axis linear-velocity computation block.
- Generates that block's periodic start pulse on a fixed 50 Hz schedule.
- Holds a stable altitude operand and discards the unreliable first result after reset or sensor dropout.
- Flags when the rangefinder has gone stale.
- Sits between the rangefinder altitude interface and the velocity computation block; outputs also feed the altitude PID.

Parameters:
PERIOD_US, 20000, schedule period in us_clk cycles (1 MHz); matches the fixed x50 rate scaling in the velocity computation.
COMP_LATENCY, 3, cycles from start_signal high until the velocity computation's result is valid.
MAX_MISSED, 3, consecutive ticks without a fresh sample before stale is declared (1..15).
PRIME_COUNT, 1, completed computations discarded after INIT or STALE recovery (1..3).
MAX_STEP_MM, 500, spike threshold in mm; used only with the optional feature.

Ports:
us_clk  input  1  1 MHz system clock
resetn  input  1  asynchronous active-low reset
alt_in_mm  input  RATE_BIT_WIDTH signed  rangefinder altitude
alt_valid  input  1  one-cycle strobe; alt_in_mm is valid in this cycle
start_signal  output  1  one-cycle start pulse to the velocity computation
z_altitude_mm  output  RATE_BIT_WIDTH signed  held altitude operand to the velocity computation
vel_valid  output  1  one-cycle pulse; velocity computation output is trustworthy
sensor_stale  output  1  level; no fresh altitude for MAX_MISSED ticks
missed_count  output  4  consecutive missed ticks, saturating at MAX_MISSED

Behaviour:
- Reset is asynchronous, active-low, clock us_clk.
  - Reset values: start_signal=0, z_altitude_mm=0, vel_valid=0, sensor_stale=0, missed_count=0.
  - Internal reset: period counter=0, fresh=0, prime counter=0, state=INIT.
- Period counter runs 0..PERIOD_US-1 and wraps. tick=1 when count==PERIOD_US-1.
- Sample capture:
  - alt_valid=1 → z_altitude_mm<=alt_in_mm and fresh<=1 on the same edge.
  - alt_valid on the tick cycle counts as fresh for that tick.
  - A sample arriving in the cycle after start_signal still updates the register. The computation block samples the pre-edge value, so no corruption occurs.
- Issue rule: at tick with (fresh|alt_valid) and state!=INIT:
  - start_signal=1 in the next cycle (registered);
  - fresh cleared (unless alt_valid in that same cycle);
  - missed_count<=0;
  - latency shift register loaded.
- Miss rule: at tick without a fresh sample, no start is issued and missed_count increments, saturating.
- Completion: vel_valid is a candidate in cycle s+COMP_LATENCY, where s is the start_signal cycle.
  - Asserted only in RUN.
  - In PRIME, each completion decrements the prime counter and vel_valid stays 0.
- State machine:
  - INIT: one cycle → PRIME; prime counter<=PRIME_COUNT.
  - PRIME: issue/miss rules apply. Prime counter reaching 0 on a completion → RUN. missed_count reaching MAX_MISSED → STALE.
  - RUN: issue/miss rules apply. missed_count reaching MAX_MISSED → STALE.
  - STALE: sensor_stale=1. Ticks without a fresh sample issue nothing. A tick with a fresh sample issues a start and → PRIME with prime counter reloaded; sensor_stale clears on that edge.
- Any completion still in flight when entering STALE is dropped: the shift register is cleared and no vel_valid is produced.
- Legality: PERIOD_US > COMP_LATENCY+2, so starts never overlap a computation in progress. Elaboration fails otherwise.
- Reset mid-operation: all state returns to reset values immediately. Pending completions are lost.

Optional Feature:
ZV_SPIKE_REJECT_EN
- Defined:
  - An alt_valid sample with |alt_in_mm − last_accepted| > MAX_STEP_MM is ignored: z_altitude_mm and fresh are unchanged.
  - The difference is computed at RATE_BIT_WIDTH+1 bits to avoid wrap.
  - The first sample after INIT or STALE is always accepted.
- Undefined: every alt_valid sample is accepted.

Decomposition:
- Shared package holds:
  - state one-hot encodings (ZVS_NUM_STATES=4);
  - RATE_BIT_WIDTH from common_defines;
  - the us-per-50 Hz constant.
- One sub-module, zvs_period_timer: parameterised wrap counter producing tick.

Test Plan:
- Reset, then alt_valid=1000 every 20000 cycles aligned before tick → first start at cycle 20000 with no vel_valid; second start has vel_valid 3 cycles later; RUN reached.
- alt_valid arriving on the exact tick cycle with value 1234 → start_signal next cycle; z_altitude_mm=1234 in the LATCH cycle.
- Stop alt_valid for 3 ticks → missed_count 1,2,3; sensor_stale=1 after the third tick; no start_signal. Resume samples → one discarded computation, then vel_valid.
- Assert resetn low two cycles after start_signal → no vel_valid; all outputs 0.
- Macro defined, last accepted=1000, sample 1600 → rejected, tick counts as a miss. Sample 1400 → accepted.
- PERIOD_US=4 with COMP_LATENCY=3 → elaboration error.

Source files
------------

// File: rtl/z_velocity_scheduler_pkg.sv
// Shared definitions for the z-axis velocity scheduler.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
//
// Contents: one-hot state encoding, altitude operand width, the 50 Hz
// period in 1 MHz clock cycles, and the spike-step comparison helper.
package z_velocity_scheduler_pkg;

    // Altitude operand width, shared with the velocity computation block.
    localparam int RATE_BIT_WIDTH = 16;

    localparam int ZVS_NUM_STATES = 4;

    // 1 MHz clock / 50 Hz schedule.
    localparam int US_PER_50HZ = 20000;

    typedef enum logic [ZVS_NUM_STATES-1:0] {
        ZVS_INIT  = 4'b0001,
        ZVS_PRIME = 4'b0010,
        ZVS_RUN   = 4'b0100,
        ZVS_STALE = 4'b1000
    } zvs_state_t;

    // True when |cur - last| <= max_step. The difference is formed one bit
    // wider than the operands so that opposite-sign extremes cannot wrap.
    function automatic logic zvs_step_ok(
        input logic signed [RATE_BIT_WIDTH-1:0] cur,
        input logic signed [RATE_BIT_WIDTH-1:0] last,
        input int                               max_step
    );
        logic signed [RATE_BIT_WIDTH:0] diff;
        diff = {cur[RATE_BIT_WIDTH-1], cur} - {last[RATE_BIT_WIDTH-1], last};
        if (diff < 0) begin
            diff = -diff;
        end
        return (int'(diff) <= max_step);
    endfunction

endpackage

// File: rtl/z_velocity_scheduler_zvs_period_timer.sv
// Free-running wrap counter 0..PERIOD-1 that flags the last count.
// Latency: tick is combinational from the count register (high for one cycle per period).
// Backpressure: none; the timer never stalls.
//
// Ports: us_clk (clock), resetn (async active-low), tick (high when count == PERIOD-1).
module zvs_period_timer #(
    parameter int PERIOD = 20000
) (
    input  logic us_clk,
    input  logic resetn,
    output logic tick
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        tick    = (count_q == CW'(PERIOD - 1));
        count_d = tick ? '0 : count_q + CW'(1);
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/z_velocity_scheduler.sv
// Schedules the z-velocity computation at 50 Hz, holds its altitude operand and gates its result.
// Latency: start_signal one cycle after the period tick; vel_valid COMP_LATENCY cycles after start_signal.
// Backpressure: none; a tick without a fresh altitude sample is a miss, not a stall.
//
// Ports: us_clk/resetn (clock, async active-low reset); alt_in_mm/alt_valid (rangefinder
// sample strobe); start_signal/z_altitude_mm (to the velocity block); vel_valid (result
// trustworthy); sensor_stale/missed_count (rangefinder health).
// Optional: define ZV_SPIKE_REJECT_EN to ignore samples stepping more than MAX_STEP_MM.
module z_velocity_scheduler
    import z_velocity_scheduler_pkg::*;
#(
    parameter int PERIOD_US    = US_PER_50HZ,
    parameter int COMP_LATENCY = 3,
    parameter int MAX_MISSED   = 3,
    parameter int PRIME_COUNT  = 1,
    parameter int MAX_STEP_MM  = 500
) (
    input  logic                             us_clk,
    input  logic                             resetn,
    input  logic signed [RATE_BIT_WIDTH-1:0] alt_in_mm,
    input  logic                             alt_valid,
    output logic                             start_signal,
    output logic signed [RATE_BIT_WIDTH-1:0] z_altitude_mm,
    output logic                             vel_valid,
    output logic                             sensor_stale,
    output logic [3:0]                       missed_count
);

    // A start must never land while the previous computation is still running.
    if (PERIOD_US <= COMP_LATENCY + 2) begin : g_bad_period
        $error("z_velocity_scheduler: PERIOD_US must exceed COMP_LATENCY+2");
    end

    logic tick;

    zvs_period_timer #(.PERIOD(PERIOD_US)) u_timer (
        .us_clk (us_clk),
        .resetn (resetn),
        .tick   (tick)
    );

    zvs_state_t                       state_q, state_d;
    logic                             fresh_q, fresh_d;
    logic [1:0]                       prime_q, prime_d;
    logic [COMP_LATENCY-1:0]          lat_q, lat_d;
    logic                             start_q, start_d;
    logic                             vel_q, vel_d;
    logic                             stale_q, stale_d;
    logic [3:0]                       missed_q, missed_d;
    logic signed [RATE_BIT_WIDTH-1:0] z_alt_q, z_alt_d;

    logic sample_ok;
    logic fresh_now;
    logic issue;
    logic miss;
    logic done;

`ifdef ZV_SPIKE_REJECT_EN
    // Set until the first sample after INIT or STALE is taken; that sample
    // has no trustworthy reference and is accepted unconditionally.
    logic first_q, first_d;

    assign sample_ok = alt_valid &&
                       (first_q || zvs_step_ok(alt_in_mm, z_alt_q, MAX_STEP_MM));
`else
    assign sample_ok = alt_valid;
`endif

    always_comb begin
        // A sample landing on the tick cycle still counts for that tick.
        fresh_now = fresh_q | sample_ok;
        issue     = tick && fresh_now && (state_q != ZVS_INIT);
        miss      = tick && !fresh_now &&
                    ((state_q == ZVS_PRIME) || (state_q == ZVS_RUN));
        done      = lat_q[COMP_LATENCY-1];

        state_d  = state_q;
        prime_d  = prime_q;
        lat_d    = lat_q << 1;
        start_d  = issue;
        vel_d    = 1'b0;
        missed_d = missed_q;
        z_alt_d  = sample_ok ? alt_in_mm : z_alt_q;
        fresh_d  = sample_ok ? 1'b1 : (issue ? 1'b0 : fresh_q);

        if (issue) begin
            missed_d = '0;
            lat_d[0] = 1'b1;
        end
        if (miss && (missed_q < 4'(MAX_MISSED))) begin
            missed_d = missed_q + 4'd1;
        end

        case (state_q)
            ZVS_INIT: begin
                state_d = ZVS_PRIME;
                prime_d = 2'(PRIME_COUNT);
            end
            ZVS_PRIME: begin
                // Completions while priming are discarded, including the last one.
                if (done) begin
                    prime_d = prime_q - 2'd1;
                    if (prime_q == 2'd1) begin
                        state_d = ZVS_RUN;
                    end
                end
            end
            ZVS_RUN: begin
                vel_d = done;
            end
            ZVS_STALE: begin
                if (issue) begin
                    state_d = ZVS_PRIME;
                    prime_d = 2'(PRIME_COUNT);
                end
            end
            default: begin
                state_d = ZVS_INIT;
            end
        endcase

        // Going stale drops any computation still in flight.
        if (((state_q == ZVS_PRIME) || (state_q == ZVS_RUN)) &&
            (missed_d == 4'(MAX_MISSED))) begin
            state_d = ZVS_STALE;
            lat_d   = '0;
            vel_d   = 1'b0;
        end

        stale_d = (state_d == ZVS_STALE);
    end

`ifdef ZV_SPIKE_REJECT_EN
    always_comb begin
        first_d = first_q;
        if ((state_q == ZVS_INIT) ||
            ((state_d == ZVS_STALE) && (state_q != ZVS_STALE))) begin
            first_d = 1'b1;
        end
        if (sample_ok) begin
            first_d = 1'b0;
        end
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            first_q <= 1'b1;
        end else begin
            first_q <= first_d;
        end
    end
`endif

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ZVS_INIT;
            fresh_q  <= 1'b0;
            prime_q  <= '0;
            lat_q    <= '0;
            start_q  <= 1'b0;
            vel_q    <= 1'b0;
            stale_q  <= 1'b0;
            missed_q <= '0;
            z_alt_q  <= '0;
        end else begin
            state_q  <= state_d;
            fresh_q  <= fresh_d;
            prime_q  <= prime_d;
            lat_q    <= lat_d;
            start_q  <= start_d;
            vel_q    <= vel_d;
            stale_q  <= stale_d;
            missed_q <= missed_d;
            z_alt_q  <= z_alt_d;
        end
    end

    assign start_signal  = start_q;
    assign z_altitude_mm = z_alt_q;
    assign vel_valid     = vel_q;
    assign sensor_stale  = stale_q;
    assign missed_count  = missed_q;

endmodule

// File: tb/tb_z_velocity_scheduler.sv
// Directed bench for z_velocity_scheduler with a shortened 20-cycle period.
// Latency: n/a.
// Backpressure: n/a.
module tb_z_velocity_scheduler;
    import z_velocity_scheduler_pkg::*;

    localparam int P = 20;
    localparam int L = 3;

    logic                             us_clk = 1'b0;
    logic                             resetn = 1'b0;
    logic signed [RATE_BIT_WIDTH-1:0] alt_in_mm = '0;
    logic                             alt_valid = 1'b0;
    logic                             start_signal;
    logic signed [RATE_BIT_WIDTH-1:0] z_altitude_mm;
    logic                             vel_valid;
    logic                             sensor_stale;
    logic [3:0]                       missed_count;

    z_velocity_scheduler #(
        .PERIOD_US    (P),
        .COMP_LATENCY (L),
        .MAX_MISSED   (3),
        .PRIME_COUNT  (1),
        .MAX_STEP_MM  (500)
    ) dut (
        .us_clk        (us_clk),
        .resetn        (resetn),
        .alt_in_mm     (alt_in_mm),
        .alt_valid     (alt_valid),
        .start_signal  (start_signal),
        .z_altitude_mm (z_altitude_mm),
        .vel_valid     (vel_valid),
        .sensor_stale  (sensor_stale),
        .missed_count  (missed_count)
    );

    always #5 us_clk = ~us_clk;

    int n_cmp = 0;
    int n_err = 0;
    // Cycle index since reset release; cycle 0 is the INIT cycle, the first tick is cycle P-1.
    int cyc = 0;
    logic seen_vel;

    task automatic step();
        @(posedge us_clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    task automatic sample(input int c, input int v);
        goto(c);
        alt_in_mm = RATE_BIT_WIDTH'(v);
        alt_valid = 1'b1;
        step();
        alt_valid = 1'b0;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_start"},  start_signal,  0);
        check({tag, "_z"},      z_altitude_mm, 0);
        check({tag, "_vel"},    vel_valid,     0);
        check({tag, "_stale"},  sensor_stale,  0);
        check({tag, "_missed"}, missed_count,  0);
    endtask

    initial begin
        repeat (3) @(posedge us_clk);
        #1;
        check_all_zero("rst_held");
        resetn = 1'b1;
        cyc    = 0;
        check_all_zero("rst_release");

        // Priming: first computation is discarded, second produces vel_valid.
        sample(10, 1000);
        check("z_first_sample", z_altitude_mm, 1000);
        goto(19); check("no_start_before_tick", start_signal, 0);
        goto(20); check("first_start", start_signal, 1);
        goto(21); check("start_one_cycle", start_signal, 0);
        goto(23); check("prime_discard", vel_valid, 0);
        sample(30, 1000);
        goto(40); check("second_start", start_signal, 1);
        goto(42); check("vel_not_early", vel_valid, 0);
        goto(43); check("run_vel", vel_valid, 1);
        goto(44); check("vel_one_cycle", vel_valid, 0);

        // Sample on the tick cycle itself.
        sample(59, 1234);
        check("tick_sample_start", start_signal, 1);
        check("tick_sample_z", z_altitude_mm, 1234);
        goto(63); check("tick_sample_vel", vel_valid, 1);
        sample(70, 1500);
        goto(80); check("start_80", start_signal, 1);
        goto(83); check("vel_83", vel_valid, 1);

        // Sensor dropout: three missed ticks -> stale.
        goto(100); check("miss1_count", missed_count, 1);
        check("miss1_no_start", start_signal, 0);
        goto(120); check("miss2_count", missed_count, 2);
        check("miss2_not_stale", sensor_stale, 0);
        goto(140); check("miss3_count", missed_count, 3);
        check("miss3_stale", sensor_stale, 1);
        check("miss3_no_start", start_signal, 0);
        goto(160); check("stale_sat_count", missed_count, 3);
        check("stale_no_start", start_signal, 0);

        // Recovery: one discarded computation, then vel_valid again.
        sample(170, 2000);
        goto(180); check("recover_start", start_signal, 1);
        check("recover_stale_clear", sensor_stale, 0);
        check("recover_missed_clear", missed_count, 0);
        check("recover_z", z_altitude_mm, 2000);
        goto(183); check("recover_discard", vel_valid, 0);
        sample(190, 2100);
        goto(200); check("recover_start2", start_signal, 1);
        goto(203); check("recover_vel", vel_valid, 1);

        // Reset two cycles after a start: the pending completion is lost.
        sample(210, 2200);
        goto(220); check("pre_reset_start", start_signal, 1);
        goto(222);
        resetn = 1'b0;
        #1;
        check_all_zero("mid_rst");
        seen_vel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            seen_vel = seen_vel | vel_valid;
        end
        resetn = 1'b1;
        cyc    = 0;
        for (int i = 0; i < 8; i++) begin
            seen_vel = seen_vel | vel_valid;
            step();
        end
        check("mid_rst_no_vel", seen_vel, 0);
        check("mid_rst_z", z_altitude_mm, 0);

`ifdef ZV_SPIKE_REJECT_EN
        // Spike rejection: 1000 -> 1600 is a 600 mm step and is ignored.
        sample(10, 1000);
        check("spike_first_accept", z_altitude_mm, 1000);
        goto(20); check("spike_first_start", start_signal, 1);
        sample(30, 1600);
        check("spike_reject_z", z_altitude_mm, 1000);
        goto(40); check("spike_counts_miss", missed_count, 1);
        check("spike_no_start", start_signal, 0);
        sample(50, 1400);
        check("spike_accept_z", z_altitude_mm, 1400);
        goto(60); check("spike_accept_start", start_signal, 1);
        check("spike_accept_missed", missed_count, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
